// File: rtl/rv32i_ctrl_pkg.sv
// Purpose: shared state encoding, opcode constants, ALU codes and writeback selects for the multicycle control unit.
// Latency: none (declarations only).
// Backpressure: none.
package rv32i_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_IL    = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [2:0] F3_SHIFT_RIGHT = 3'b101;

  localparam logic [1:0] WRSEL_ALU  = 2'd0;
  localparam logic [1:0] WRSEL_LOAD = 2'd1;
  localparam logic [1:0] WRSEL_PC4  = 2'd2;
  localparam logic [1:0] WRSEL_IMM  = 2'd3;

endpackage

// File: rtl/mc_decoder.sv
// Purpose: purely combinational opcode/funct decode into static control fields.
// Latency: zero cycles (combinational).
// Backpressure: none; outputs follow the instruction fields directly.
module mc_decoder
  import rv32i_ctrl_pkg::*;
(
  input  logic [6:0] iOpcode,
  input  logic [2:0] iFunct3,
  input  logic [6:0] iFunct7,
  output logic       oLegal,
  output logic       oIsLoad,
  output logic       oIsStore,
  output logic       oIsBranch,
  output logic       oIsJump,
  output logic       oWritesReg,
  output logic [3:0] oALU_Control,
  output logic       oALUSrcMuxSel,
  output logic [1:0] oRegWrDataSel
);

  // Only funct7[5] distinguishes SUB/SRA; the remaining bits carry no control meaning.
  logic unusedFunct7;
  assign unusedFunct7 = ^{iFunct7[6], iFunct7[4:0]};

  // Opcode lookup; an unknown opcode leaves everything at zero with oLegal low.
  always_comb begin
    oLegal        = 1'b0;
    oIsLoad       = 1'b0;
    oIsStore      = 1'b0;
    oIsBranch     = 1'b0;
    oIsJump       = 1'b0;
    oWritesReg    = 1'b0;
    oALU_Control  = ALU_ADD;
    oALUSrcMuxSel = 1'b0;
    oRegWrDataSel = WRSEL_ALU;
    case (iOpcode)
      OP_R: begin
        oLegal       = 1'b1;
        oWritesReg   = 1'b1;
        oALU_Control = {iFunct7[5], iFunct3};
      end
      OP_I: begin
        oLegal        = 1'b1;
        oWritesReg    = 1'b1;
        oALUSrcMuxSel = 1'b1;
        // Only SRAI/SRLI use funct7[5]; for other immediates those bits are immediate data.
        oALU_Control  = (iFunct3 == F3_SHIFT_RIGHT) ? {iFunct7[5], iFunct3} : {1'b0, iFunct3};
      end
      OP_IL: begin
        oLegal        = 1'b1;
        oIsLoad       = 1'b1;
        oALUSrcMuxSel = 1'b1;
        oRegWrDataSel = WRSEL_LOAD;
      end
      OP_S: begin
        oLegal        = 1'b1;
        oIsStore      = 1'b1;
        oALUSrcMuxSel = 1'b1;
      end
      OP_B: begin
        oLegal       = 1'b1;
        oIsBranch    = 1'b1;
        oALU_Control = {1'b0, iFunct3};
      end
      OP_LUI: begin
        oLegal        = 1'b1;
        oWritesReg    = 1'b1;
        oRegWrDataSel = WRSEL_IMM;
      end
      OP_AUIPC: begin
        oLegal        = 1'b1;
        oWritesReg    = 1'b1;
        oALUSrcMuxSel = 1'b1;
      end
      OP_JAL: begin
        oLegal        = 1'b1;
        oIsJump       = 1'b1;
        oWritesReg    = 1'b1;
        oRegWrDataSel = WRSEL_PC4;
      end
      OP_JALR: begin
        oLegal        = 1'b1;
        oIsJump       = 1'b1;
        oWritesReg    = 1'b1;
        oALUSrcMuxSel = 1'b1;
        oRegWrDataSel = WRSEL_PC4;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Purpose: multicycle RV32I control FSM (FETCH/DECODE/EXECUTE/MEM/WB) driving datapath strobes.
// Latency: 3 cycles for ALU/branch/jump with single-cycle fetch, plus MEM wait and WB for loads.
// Backpressure: stalls in MEM until iMem_Ack, aborting with oFault after MEM_TIMEOUT cycles.
module mc_control_unit
  import rv32i_ctrl_pkg::*;
#(
  parameter int FETCH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 16
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [31:0] iInst_Code,
  input  logic        iMem_Ack,
  output logic [2:0]  oState,
  output logic        oPC_En,
  output logic        oIR_En,
  output logic [2:0]  oFunct3,
  output logic [3:0]  oALU_Control,
  output logic [1:0]  oRegWrDataSel,
  output logic        oALUSrcMuxSel,
  output logic        oWrEn,
  output logic        oData_WrEn,
  output logic        oData_RdEn,
  output logic        oBranch,
  output logic        oJump,
  output logic        oFault
);

  localparam logic [3:0] FETCH_LAST = 4'(FETCH_CYCLES - 1);
  localparam logic [7:0] MEM_LAST   = 8'(MEM_TIMEOUT - 1);

  state_t     state, stateNext;
  logic [3:0] fetchCnt, fetchCntNext;
  logic [7:0] memCnt, memCntNext;
  logic       fetchLast, memLast;

  logic       legal, isLoad, isStore, isBranch, isJump, writesReg;
  logic [3:0] aluCtrl;
  logic       aluSrc;
  logic [1:0] regWrSel;

  logic       pcEn, irEn, wrEn, dataWrEn, dataRdEn, branch, fault;

  // Register, rs1/rs2 and immediate fields belong to the datapath, not to control.
  logic unusedInstBits;
  assign unusedInstBits = ^{iInst_Code[24:15], iInst_Code[11:7]};

  mc_decoder uDecoder (
    .iOpcode       (iInst_Code[6:0]),
    .iFunct3       (iInst_Code[14:12]),
    .iFunct7       (iInst_Code[31:25]),
    .oLegal        (legal),
    .oIsLoad       (isLoad),
    .oIsStore      (isStore),
    .oIsBranch     (isBranch),
    .oIsJump       (isJump),
    .oWritesReg    (writesReg),
    .oALU_Control  (aluCtrl),
    .oALUSrcMuxSel (aluSrc),
    .oRegWrDataSel (regWrSel)
  );

  assign fetchLast = (fetchCnt >= FETCH_LAST);
  assign memLast   = (memCnt >= MEM_LAST);

  // State and counter registers with synchronous reset back to the start of FETCH.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state    <= ST_FETCH;
      fetchCnt <= '0;
      memCnt   <= '0;
    end else begin
      state    <= stateNext;
      fetchCnt <= fetchCntNext;
      memCnt   <= memCntNext;
    end
  end

  // Next-state and raw strobe generation; strobes depend only on state, opcode, counters and ack.
  always_comb begin
    stateNext = state;
    pcEn      = 1'b0;
    irEn      = 1'b0;
    wrEn      = 1'b0;
    dataWrEn  = 1'b0;
    dataRdEn  = 1'b0;
    branch    = 1'b0;
    fault     = 1'b0;
    case (state)
      ST_FETCH: begin
        if (fetchLast) begin
          irEn      = 1'b1;
          stateNext = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (legal) begin
          stateNext = ST_EXECUTE;
        end else begin
          // Skip the illegal word so the machine keeps making forward progress.
          fault     = 1'b1;
          pcEn      = 1'b1;
          stateNext = ST_FETCH;
        end
      end
      ST_EXECUTE: begin
        if (isLoad || isStore) begin
          stateNext = ST_MEM;
        end else begin
          pcEn      = 1'b1;
          wrEn      = writesReg;
          branch    = isBranch;
          stateNext = ST_FETCH;
        end
      end
      ST_MEM: begin
        dataRdEn = isLoad;
        dataWrEn = isStore;
        // An ack on the final allowed cycle takes priority over the timeout.
        if (iMem_Ack) begin
          if (isLoad) begin
            stateNext = ST_WB;
          end else begin
            pcEn      = 1'b1;
            stateNext = ST_FETCH;
          end
        end else if (memLast) begin
          fault     = 1'b1;
          pcEn      = 1'b1;
          stateNext = ST_FETCH;
        end
      end
      ST_WB: begin
        wrEn      = 1'b1;
        pcEn      = 1'b1;
        stateNext = ST_FETCH;
      end
      default: stateNext = ST_FETCH;
    endcase
  end

  // Saturating counters: fetch counts within FETCH, timeout counts MEM cycles without ack.
  always_comb begin
    fetchCntNext = '0;
    memCntNext   = '0;
    if (state == ST_FETCH && stateNext == ST_FETCH && fetchCnt != 4'hF) begin
      fetchCntNext = fetchCnt + 4'd1;
    end else if (state == ST_FETCH && stateNext == ST_FETCH) begin
      fetchCntNext = fetchCnt;
    end
    if (state == ST_MEM && stateNext == ST_MEM && memCnt != 8'hFF) begin
      memCntNext = memCnt + 8'd1;
    end else if (state == ST_MEM && stateNext == ST_MEM) begin
      memCntNext = memCnt;
    end
  end

  assign oState        = state;
  assign oFunct3       = iInst_Code[14:12];
  assign oPC_En        = pcEn & ~iRst;
  assign oIR_En        = irEn & ~iRst;
  assign oWrEn         = wrEn & ~iRst;
  assign oData_WrEn    = dataWrEn & ~iRst;
  assign oData_RdEn    = dataRdEn & ~iRst;
  assign oBranch       = branch & ~iRst;
  assign oFault        = fault & ~iRst;
  assign oJump         = isJump & (state != ST_FETCH) & ~iRst;
  assign oALU_Control  = iRst ? 4'd0 : aluCtrl;
  assign oRegWrDataSel = iRst ? 2'd0 : regWrSel;
  assign oALUSrcMuxSel = aluSrc & ~iRst;

endmodule
